// File: rtl/vol_ramp_ctrl_if.sv
// -----------------------------------------------------------------------------
// vol_ramp_ctrl_if
// Volume-word handshake between the ramp controller (master) and the MP3 SCI
// writer (slave).
//   o_vol        16  SCI_VOL word {att, att}, driven by the controller
//   o_vol_valid   1  o_vol holds a new value awaiting i_vol_ack
//   i_vol_ack     1  SCI writer has accepted o_vol
// -----------------------------------------------------------------------------
interface vol_ramp_ctrl_if;
   logic [15:0] o_vol;
   logic        o_vol_valid;
   logic        i_vol_ack;

   modport master (
      output o_vol,
      output o_vol_valid,
      input  i_vol_ack
   );

   modport slave (
      input  o_vol,
      input  o_vol_valid,
      output i_vol_ack
   );
endinterface

// File: rtl/vol_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// vol_ramp_ctrl
// Volume level register with a ramped attenuation output for the VS1003
// SCI_VOL register. Level changes and pause produce a target attenuation;
// the current attenuation walks toward it and each new value is handed to the
// SCI writer through a valid/ack handshake.
//
// Configuration macro: VOL_RAMP_EN
//   defined   : attenuation moves one LSB every RAMP_DIV clocks
//   undefined : attenuation jumps to the target in one cycle (no divider)
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   i_vol_plus   in   one-cycle pulse, one level louder
//   i_vol_dec    in   one-cycle pulse, one level quieter
//   i_pause      in   level, high fades to silence
//   vif          --   master side of vol_ramp_ctrl_if (o_vol/o_vol_valid/i_vol_ack)
//   o_vol_level  out  target level 0 (loudest) .. 8 (quietest)
//   o_silent     out  current attenuation equals 0xFE
// -----------------------------------------------------------------------------
module vol_ramp_ctrl #(
   parameter int unsigned RAMP_DIV   = 100000,
   parameter int unsigned STEP       = 16,
   parameter int unsigned INIT_LEVEL = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_vol_plus,
   input  logic                   i_vol_dec,
   input  logic                   i_pause,
   vol_ramp_ctrl_if.master        vif,
   output logic [3:0]             o_vol_level,
   output logic                   o_silent
);

   localparam logic [3:0] MAX_LEVEL  = 4'd8;
   localparam logic [3:0] INIT_LVL   = 4'(INIT_LEVEL);
   localparam logic [7:0] STEP_B     = 8'(STEP);
   localparam logic [7:0] SILENT_ATT = 8'hFE;
   localparam logic [7:0] INIT_ATT   = 8'(INIT_LEVEL * STEP);

   // Parameter sanity: the level*STEP product must fit below the silent code.
   if (RAMP_DIV < 1 || STEP * 8 > 254 || INIT_LEVEL > 8) begin : g_cfg_check
      $error("vol_ramp_ctrl: illegal RAMP_DIV/STEP/INIT_LEVEL");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_PEND = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] level_q, level_d;
   logic [7:0] att_q, att_d;
   logic       valid_q, valid_d;
   logic [7:0] target_s;

`ifdef VOL_RAMP_EN
   localparam int unsigned     DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(RAMP_DIV - 1);
   logic [DIV_W-1:0] div_q, div_d;
`endif

   // Level next-state: simultaneous plus/dec cancel, both ends saturate.
   always_comb begin
      level_d = level_q;
      if (i_vol_plus && !i_vol_dec) begin
         if (level_q != 4'd0) begin
            level_d = level_q - 4'd1;
         end else begin
            level_d = level_q;
         end
      end else if (i_vol_dec && !i_vol_plus) begin
         if (level_q != MAX_LEVEL) begin
            level_d = level_q + 4'd1;
         end else begin
            level_d = level_q;
         end
      end else begin
         level_d = level_q;
      end
   end

   // Target attenuation, re-evaluated every cycle from the latched level.
   always_comb begin
      target_s = {4'd0, level_q} * STEP_B;
      if (i_pause) begin
         target_s = SILENT_ATT;
      end else begin
         target_s = {4'd0, level_q} * STEP_B;
      end
   end

   // FSM next-state and datapath; att is only touched on the step that raises valid,
   // so o_vol never moves while a word is pending.
   always_comb begin
      state_d = state_q;
      att_d   = att_q;
      valid_d = valid_q;
`ifdef VOL_RAMP_EN
      div_d   = div_q;
`endif
      case (state_q)
         ST_IDLE: begin
            valid_d = 1'b0;
            if (att_q != target_s) begin
`ifdef VOL_RAMP_EN
               div_d   = DIV_LOAD;
               state_d = ST_WAIT;
`else
               att_d   = target_s;
               valid_d = 1'b1;
               state_d = ST_PEND;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef VOL_RAMP_EN
         ST_WAIT: begin
            if (div_q != '0) begin
               div_d = div_q - DIV_W'(1);
            end else if (att_q != target_s) begin
               // Step direction follows whatever the target is at expiry.
               if (att_q < target_s) begin
                  att_d = att_q + 8'd1;
               end else begin
                  att_d = att_q - 8'd1;
               end
               valid_d = 1'b1;
               state_d = ST_PEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
`endif
         ST_PEND: begin
            if (vif.i_vol_ack) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end else begin
               valid_d = 1'b1;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, level, attenuation and valid registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         level_q <= INIT_LVL;
         att_q   <= INIT_ATT;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         att_q   <= att_d;
         valid_q <= valid_d;
      end
   end

`ifdef VOL_RAMP_EN
   // Step divider register.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end
`endif

   assign vif.o_vol       = {att_q, att_q};
   assign vif.o_vol_valid = valid_q;
   assign o_vol_level     = level_q;
   assign o_silent        = (att_q == SILENT_ATT);

endmodule

// File: tb/tb_vol_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vol_ramp_ctrl
// Directed self-checking bench for vol_ramp_ctrl (RAMP_DIV = 4). Expected
// values are hand-computed; the ramp sequence is compiled when VOL_RAMP_EN is
// defined, the one-cycle-load sequence otherwise.
// -----------------------------------------------------------------------------
module tb_vol_ramp_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       vol_plus;
   logic       vol_dec;
   logic       pause;
   logic [3:0] vol_level;
   logic       silent;
   int         n_tests = 0;
   int         n_fail  = 0;

   vol_ramp_ctrl_if vif ();

   vol_ramp_ctrl #(
      .RAMP_DIV   (4),
      .STEP       (16),
      .INIT_LEVEL (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_vol_plus  (vol_plus),
      .i_vol_dec   (vol_dec),
      .i_pause     (pause),
      .vif         (vif.master),
      .o_vol_level (vol_level),
      .o_silent    (silent)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against its expectation.
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Pulse plus/dec for one cycle then give the handshake time to finish (ack high).
   task automatic pulse(input logic p, input logic d);
      vol_plus = p;
      vol_dec  = d;
      tick();
      vol_plus = 1'b0;
      vol_dec  = 1'b0;
      tick();
      tick();
      tick();
   endtask

   initial begin
      rst           = 1'b1;
      vol_plus      = 1'b0;
      vol_dec       = 1'b0;
      pause         = 1'b0;
      vif.i_vol_ack = 1'b1;
      tick();
      tick();
      check("rst_vol",    32'(vif.o_vol), 32'h2020);
      check("rst_valid",  32'(vif.o_vol_valid), 32'd0);
      check("rst_level",  32'(vol_level), 32'd2);
      check("rst_silent", 32'(silent), 32'd0);
      rst = 1'b0;
      tick();
      check("post_rst_valid", 32'(vif.o_vol_valid), 32'd0);
      check("post_rst_vol",   32'(vif.o_vol), 32'h2020);

`ifndef VOL_RAMP_EN
      // One dec pulse: level latched, then att loaded one cycle later.
      vif.i_vol_ack = 1'b0;
      vol_dec = 1'b1;
      tick();
      vol_dec = 1'b0;
      check("dec_level", 32'(vol_level), 32'd3);
      check("dec_valid_early", 32'(vif.o_vol_valid), 32'd0);
      tick();
      check("dec_valid", 32'(vif.o_vol_valid), 32'd1);
      check("dec_vol",   32'(vif.o_vol), 32'h3030);
      // Ack withheld: word must hold steady.
      for (int i = 0; i < 20; i++) begin
         tick();
         check("hold_valid", 32'(vif.o_vol_valid), 32'd1);
         check("hold_vol",   32'(vif.o_vol), 32'h3030);
      end
      vif.i_vol_ack = 1'b1;
      tick();
      check("ack_clear", 32'(vif.o_vol_valid), 32'd0);
      pulse(1'b0, 1'b1);
      check("lvl4_level", 32'(vol_level), 32'd4);
      check("lvl4_vol",   32'(vif.o_vol), 32'h4040);

      // Simultaneous plus and dec cancel.
      vol_plus = 1'b1;
      vol_dec  = 1'b1;
      tick();
      vol_plus = 1'b0;
      vol_dec  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("both_valid", 32'(vif.o_vol_valid), 32'd0);
      end
      check("both_level", 32'(vol_level), 32'd4);
      check("both_vol",   32'(vif.o_vol), 32'h4040);

      // Quiet end saturation.
      repeat (4) pulse(1'b0, 1'b1);
      check("lvl8_level", 32'(vol_level), 32'd8);
      check("lvl8_vol",   32'(vif.o_vol), 32'h8080);
      pulse(1'b0, 1'b1);
      check("sat8_level", 32'(vol_level), 32'd8);
      check("sat8_vol",   32'(vif.o_vol), 32'h8080);

      // Pause to silence and back.
      pause = 1'b1;
      tick();
      check("pause_vol",    32'(vif.o_vol), 32'hFEFE);
      check("pause_silent", 32'(silent), 32'd1);
      check("pause_valid",  32'(vif.o_vol_valid), 32'd1);
      tick();
      pause = 1'b0;
      tick();
      check("resume_vol",    32'(vif.o_vol), 32'h8080);
      check("resume_silent", 32'(silent), 32'd0);
      tick();

      // Loud end saturation.
      repeat (13) pulse(1'b1, 1'b0);
      check("sat0_level", 32'(vol_level), 32'd0);
      check("sat0_vol",   32'(vif.o_vol), 32'h0000);

      // Reset while a word is pending aborts it.
      vif.i_vol_ack = 1'b0;
      vol_dec = 1'b1;
      tick();
      vol_dec = 1'b0;
      tick();
      check("pend_valid", 32'(vif.o_vol_valid), 32'd1);
      check("pend_vol",   32'(vif.o_vol), 32'h1010);
      rst = 1'b1;
      tick();
      check("abort_valid", 32'(vif.o_vol_valid), 32'd0);
      check("abort_level", 32'(vol_level), 32'd2);
      check("abort_vol",   32'(vif.o_vol), 32'h2020);
      rst = 1'b0;
      tick();
      check("abort_post_valid", 32'(vif.o_vol_valid), 32'd0);
      vif.i_vol_ack = 1'b1;

      // Pause held through reset: starts at 0x20, goes silent after release.
      pause = 1'b1;
      rst   = 1'b1;
      tick();
      check("prst_vol",    32'(vif.o_vol), 32'h2020);
      check("prst_silent", 32'(silent), 32'd0);
      rst = 1'b0;
      tick();
      tick();
      check("prst_fade_vol",    32'(vif.o_vol), 32'hFEFE);
      check("prst_fade_silent", 32'(silent), 32'd1);
      pause = 1'b0;
      tick();
      tick();
      tick();
      check("prst_back_vol", 32'(vif.o_vol), 32'h2020);
`else
      begin
         int t       = 0;
         int first_t = 0;
         int last_t  = 0;
         int n_valid = 0;
         int bad_gap = 0;
         // Three dec pulses: 0x20 -> 0x50 one LSB per step.
         vol_dec = 1'b1;
         tick();
         vol_dec = 1'b0;
         while (t < 2000 && !(vif.o_vol == 16'h5050 && !vif.o_vol_valid)) begin
            vol_dec = (t == 1 || t == 3);
            tick();
            vol_dec = 1'b0;
            t++;
            if (vif.o_vol_valid) begin
               n_valid++;
               if (first_t == 0) begin
                  first_t = t;
               end else if (t - last_t != 6) begin
                  bad_gap++;
               end
               last_t = t;
            end
         end
         check("ramp_timeout",   32'(t < 2000), 32'd1);
         check("ramp_first_lat", 32'(first_t), 32'd5);
         check("ramp_gaps",      32'(bad_gap), 32'd0);
         check("ramp_steps",     32'(n_valid), 32'd48);
         check("ramp_level",     32'(vol_level), 32'd5);
         check("ramp_vol",       32'(vif.o_vol), 32'h5050);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
